ofm_pack_buf: RTL and testbench

OFM_PACK_BUF -- requirements
Module: ofm_pack_buf

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/ofm_pack_buf.sv | 172 +++++++++++++++++
 tb/tb_ofm_pack_buf.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg -- shared types and helpers for the CNN output-feature-map blocks.
//
// Contents:
//   mode_e      : source/mode select, FULLY_CONVOL (0) or POOLING (1).
//   pack_fsm_e  : packer FSM states, FILL and STALL.
//   calc_out_w  : packed output word width = header + lanes * sample width.
// ---------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic {
    FULLY_CONVOL = 1'b0,
    POOLING      = 1'b1
  } mode_e;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } pack_fsm_e;

  function automatic int calc_out_w(input int hdr_w, input int lanes, input int data_w);
    return hdr_w + lanes * data_w;
  endfunction

endpackage

// File: rtl/ofm_pack_buf.sv
// ---------------------------------------------------------------------------
// ofm_pack_buf -- packs activation or pooling samples into wide output words.
//
// Samples are accepted on in_valid/in_ready, written MSB-lane first into an
// accumulator, and moved into an output register (out_valid/out_ready) when
// the word is full, flushed, or the mode changes. A word that cannot move
// because the output register is occupied parks the FSM in STALL.
//
// Word layout: { HDR_W copies of mode, lane 0, lane 1, ..., lane LANES-1 }.
// Unfilled lanes are zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   sel                  FULLY_CONVOL (0) selects act_data, POOLING (1) pool_data
//   in_valid / in_ready  input sample handshake
//   act_data, pool_data  sample sources, DATA_W bits each
//   flush                pulse, emit the partial word if one exists
//   out_valid/out_ready  output word handshake
//   out_data             packed word, OUT_W bits
//   out_count            number of valid lanes in out_data
//   busy                 accumulator non-empty or out_valid high
//   out_parity           (OFM_PARITY_EN only) even parity over out_data
//
// Build option: define OFM_PARITY_EN to add the out_parity port.
// ---------------------------------------------------------------------------
module ofm_pack_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 3,
  parameter int HDR_W  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      sel,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_W-1:0]                         act_data,
  input  logic [DATA_W-1:0]                         pool_data,
  input  logic                                      flush,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [calc_out_w(HDR_W,LANES,DATA_W)-1:0] out_data,
  output logic [3:0]                                out_count,
  output logic                                      busy
`ifdef OFM_PARITY_EN
  ,
  output logic                                      out_parity
`endif
);

  localparam int OUT_W = calc_out_w(HDR_W, LANES, DATA_W);
  localparam int ACC_W = LANES * DATA_W;
  localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

  pack_fsm_e          state_q, state_nxt;
  mode_e              mode_q, mode_nxt, sel_mode;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic [3:0]         lane_cnt_q, cnt_nxt;
  logic [DATA_W-1:0]  din;
  logic               mode_mismatch;
  logic               accept;
  logic               close_word;
  logic               out_free;
  logic               load_out;
  logic               hdr_bit;
  logic [OUT_W-1:0]   word;

  assign sel_mode = mode_e'(sel);
  assign busy     = (lane_cnt_q != 4'd0) || out_valid;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves a signal unassigned; that is what keeps latches from appearing.
  always_comb begin
    din           = act_data;
    acc_nxt       = acc_q;
    cnt_nxt       = lane_cnt_q;
    mode_nxt      = mode_q;
    close_word    = 1'b0;
    state_nxt     = state_q;

    unique case (sel_mode)
      FULLY_CONVOL: din = act_data;
      POOLING:      din = pool_data;
      default:      din = act_data;
    endcase

    // A mode change against a partially filled word closes that word first;
    // the new sample waits for an empty accumulator.
    mode_mismatch = (lane_cnt_q != 4'd0) && (sel_mode != mode_q);
    in_ready      = (state_q == FILL) && !mode_mismatch;
    accept        = in_valid && in_ready;

    if (accept) begin
      acc_nxt[(LANES - 1 - int'(lane_cnt_q)) * DATA_W +: DATA_W] = din;
      cnt_nxt = lane_cnt_q + 4'd1;
      if (lane_cnt_q == 4'd0) begin
        mode_nxt = sel_mode;
      end
    end

    unique case (state_q)
      FILL: begin
        // cnt_nxt already includes a sample accepted this cycle, so a flush
        // coincident with a handshake carries that sample.
        close_word = (accept && (lane_cnt_q == LAST_LANE))
                   || (flush && (cnt_nxt != 4'd0))
                   || (in_valid && mode_mismatch);
      end
      STALL: close_word = 1'b1;
      default: close_word = 1'b0;
    endcase

    out_free = !out_valid || out_ready;
    load_out = close_word && out_free;

    if (load_out) begin
      state_nxt = FILL;
    end else if (close_word) begin
      state_nxt = STALL;
    end

    hdr_bit = (mode_nxt == POOLING);
    word    = {{HDR_W{hdr_bit}}, acc_nxt};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_nxt;
    end
  end

  // NOTE: the accumulator is reset, not just the lane counter: the unfilled
  // lanes of a partial word are emitted as-is and must be zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      lane_cnt_q <= 4'd0;
      mode_q     <= FULLY_CONVOL;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= 4'd0;
`ifdef OFM_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (load_out) begin
        out_valid  <= 1'b1;
        out_data   <= word;
        out_count  <= cnt_nxt;
`ifdef OFM_PARITY_EN
        out_parity <= ^word;
`endif
        acc_q      <= '0;
        lane_cnt_q <= 4'd0;
        mode_q     <= mode_nxt;
      end else begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
        acc_q      <= acc_nxt;
        lane_cnt_q <= cnt_nxt;
        mode_q     <= mode_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ofm_pack_buf.sv
// ---------------------------------------------------------------------------
// tb_ofm_pack_buf -- self-checking bench for ofm_pack_buf (default params).
// Expected words are pushed to a queue by a bench-side packing model as
// samples are sent and compared when the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_ofm_pack_buf;

  localparam int DATA_W = 8;
  localparam int LANES  = 3;
  localparam int HDR_W  = 8;
  localparam int OUT_W  = HDR_W + LANES * DATA_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [3:0]       cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sel = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] act_data = '0;
  logic [DATA_W-1:0] pool_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic [3:0]        out_count;
  logic              busy;
`ifdef OFM_PARITY_EN
  logic              out_parity;
`endif

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // bench packing model
  logic [LANES*DATA_W-1:0] m_acc = '0;
  int                      m_cnt = 0;
  logic                    m_mode = 1'b0;

  logic             rnd_en = 1'b0;
  logic             hold_prev = 1'b0;
  logic [OUT_W-1:0] data_prev = '0;
  logic [3:0]       cnt_prev = '0;

  ofm_pack_buf #(.DATA_W(DATA_W), .LANES(LANES), .HDR_W(HDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_data  (act_data),
    .pool_data (pool_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
`ifdef OFM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rnd_en) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard compare on each handshake, hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        checks++;
        if (out_data !== data_prev || out_count !== cnt_prev) begin
          errors++;
          $display("FAIL hold_stable: got %h/%0d required %h/%0d", out_data, out_count, data_prev, cnt_prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h/%0d required no word", out_data, out_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.data || out_count !== e.cnt) begin
            errors++;
            $display("FAIL word: got %h/%0d required %h/%0d", out_data, out_count, e.data, e.cnt);
          end
        end
`ifdef OFM_PARITY_EN
        checks++;
        if (out_parity !== ^out_data) begin
          errors++;
          $display("FAIL parity: got %b required %b", out_parity, ^out_data);
        end
`endif
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
      cnt_prev  = out_count;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic model_emit();
    exp_t e;
    e.data = {{HDR_W{m_mode}}, m_acc};
    e.cnt  = 4'(m_cnt);
    exp_q.push_back(e);
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic send(input logic s, input logic [DATA_W-1:0] d);
    bit accepted = 0;
    int n = 0;
    if (m_cnt > 0 && s != m_mode) model_emit();
    if (m_cnt == 0) m_mode = s;
    m_acc = m_acc | ((LANES*DATA_W)'(d) << (DATA_W * (LANES - 1 - m_cnt)));
    m_cnt++;
    if (m_cnt == LANES) model_emit();

    sel       = s;
    act_data  = s ? DATA_W'($urandom) : d;
    pool_data = s ? d : DATA_W'($urandom);
    in_valid  = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic pulse_flush();
    if (m_cnt > 0) model_emit();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    if (out_count !== 4'd0) begin errors++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    send(1'b0, 8'h33);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0011_2233 || out_count !== 4'd3) begin
      errors++;
      $display("FAIL full_word_latency: got %b/%h/%0d required 1/00112233/3", out_valid, out_data, out_count);
    end
    wait_empty("full_word");
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(1'b1, 8'hAA);
    send(1'b1, 8'hBB);
    pulse_flush();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFAA_BB00 || out_count !== 4'd2) begin
      errors++;
      $display("FAIL flush_word: got %b/%h/%0d required 1/ffaabb00/2", out_valid, out_data, out_count);
    end
    wait_empty("flush");
    // flush with an empty accumulator must not emit anything
    pulse_flush();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush: got out_valid %b required 0", out_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(1'b0, 8'(i));
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
    if (out_data !== 32'h0001_0203 || out_count !== 4'd3) begin
      errors++;
      $display("FAIL stall_hold: got %h/%0d required 00010203/3", out_data, out_count);
    end
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0004_0506) begin
      errors++;
      $display("FAIL no_bubble: got %b/%h required 1/00040506", out_valid, out_data);
    end
    wait_empty("back_to_back");
  endtask

  task automatic test_mode_switch();
    out_ready = 1'b1;
    send(1'b0, 8'h44);
    send(1'b1, 8'h55);
    pulse_flush();
    wait_empty("mode_switch");
    checks++;
    if (out_data !== 32'hFF55_0000 || out_count !== 4'd1) begin
      errors++;
      $display("FAIL mode_switch_last: got %h/%0d required ff550000/1", out_data, out_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(1'b1, 8'h66);
    send(1'b1, 8'h77);
    #2 rst_n = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_count !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b/%h/%0d/%b required 0/0/0/0", out_valid, out_data, out_count, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: got out_valid %b required 0", out_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic s = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      send(s, 8'($urandom));
      if ($urandom_range(0, 6) == 0) pulse_flush();
    end
    pulse_flush();
    rnd_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_empty("random");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
